// File: rtl/turf_plot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : turf_plot_sequencer
//  Description : VGA plot scheduler for the N-player turf game. While the game
//                runs it plots one player-head pixel per cycle round-robin,
//                followed by one timer-bar pixel per round. At game end it
//                sweeps the frame black, renders one ranked digit glyph per
//                player, then idles in DONE until restarted. A mid-game clear
//                request blanks the screen and returns to play.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50      in   system clock
//    resetn        in   asynchronous active-low reset
//    running       in   game-active level
//    clear_req     in   single-cycle mid-game blank request (RUN only)
//    restart       in   single-cycle request to leave DONE
//    player_pos    in   packed {x,y} per player, player 0 in the LSBs
//    player_colour in   head colour per player
//    timer_x       in   timer-bar column
//    rank_colours  in   colour for glyph k in field k
//    glyph_bits    in   bitmap for glyph k in field k (MSB = top-left pixel)
//    x, y, colour  out  registered plot coordinates and colour
//    plot          out  pixel write strobe
//    phase         out  0 RUN, 1 CLEAR, 2 GLYPH, 3 DONE
//    done          out  high in DONE
// ============================================================================
module turf_plot_sequencer #(
    parameter int NUM_PLAYERS = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int TIMER_Y     = 119,
    parameter int GLYPH_W     = 5,
    parameter int GLYPH_H     = 7,
    parameter int GLYPH_X0    = 33,
    parameter int GLYPH_Y0    = 42,
    parameter int GLYPH_PITCH = 30
) (
    input  logic                                   CLOCK_50,
    input  logic                                   resetn,
    input  logic                                   running,
    input  logic                                   clear_req,
    input  logic                                   restart,
    input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]       player_pos,
    input  logic [NUM_PLAYERS*3-1:0]               player_colour,
    input  logic [X_W-1:0]                         timer_x,
    input  logic [NUM_PLAYERS*3-1:0]               rank_colours,
    input  logic [NUM_PLAYERS*GLYPH_W*GLYPH_H-1:0] glyph_bits,
    output logic [X_W-1:0]                         x,
    output logic [Y_W-1:0]                         y,
    output logic [2:0]                             colour,
    output logic                                   plot,
    output logic [1:0]                             phase,
    output logic                                   done
);

    // Player/glyph index width; arrays are padded to a power of two so the
    // index width matches the array depth exactly.
    localparam int c_k_w    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int c_k_n    = 1 << c_k_w;
    localparam int c_slot_w = $clog2(NUM_PLAYERS + 1);
    localparam int c_col_w  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int c_row_w  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int c_gbits  = GLYPH_W * GLYPH_H;
    localparam int c_bit_w  = (c_gbits > 1) ? $clog2(c_gbits) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GLYPH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Unpack the per-player buses into indexable arrays
    // ------------------------------------------------------------------
    logic [X_W-1:0]     w_px    [c_k_n];
    logic [Y_W-1:0]     w_py    [c_k_n];
    logic [2:0]         w_pcol  [c_k_n];
    logic [2:0]         w_rcol  [c_k_n];
    logic [c_gbits-1:0] w_glyph [c_k_n];

    generate
        for (genvar gi = 0; gi < c_k_n; gi++) begin : g_unpack
            if (gi < NUM_PLAYERS) begin : g_live
                assign w_px[gi]    = player_pos[gi*(X_W+Y_W)+Y_W +: X_W];
                assign w_py[gi]    = player_pos[gi*(X_W+Y_W) +: Y_W];
                assign w_pcol[gi]  = player_colour[gi*3 +: 3];
                assign w_rcol[gi]  = rank_colours[gi*3 +: 3];
                assign w_glyph[gi] = glyph_bits[gi*c_gbits +: c_gbits];
            end else begin : g_pad
                assign w_px[gi]    = '0;
                assign w_py[gi]    = '0;
                assign w_pcol[gi]  = '0;
                assign w_rcol[gi]  = '0;
                assign w_glyph[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t              r_state, w_state_nxt;
    logic [c_slot_w-1:0] r_slot,  w_slot_nxt;
    logic [X_W-1:0]      r_cx,    w_cx_nxt;
    logic [Y_W-1:0]      r_cy,    w_cy_nxt;
    logic [c_row_w-1:0]  r_gr,    w_gr_nxt;
    logic [c_col_w-1:0]  r_gc,    w_gc_nxt;
    logic [c_k_w-1:0]    r_gk,    w_gk_nxt;
    logic                r_clr_latch, w_clr_latch_nxt;
    logic                r_ret,   w_ret_nxt;
    logic [X_W-1:0]      r_x,     w_x_nxt;
    logic [Y_W-1:0]      r_y,     w_y_nxt;
    logic [2:0]          r_col,   w_col_nxt;
    logic                r_plot,  w_plot_nxt;
    logic                r_done,  w_done_nxt;

    logic [c_k_w-1:0]    w_pk;
    logic [X_W-1:0]      w_gx;
    logic [Y_W-1:0]      w_gy;
    logic [c_bit_w-1:0]  w_bit_idx;
    logic [c_gbits-1:0]  w_gmap;

    assign w_pk = r_slot[c_k_w-1:0];
    assign w_gx = X_W'(GLYPH_X0) + X_W'(r_gk) * X_W'(GLYPH_PITCH) + X_W'(r_gc);
    assign w_gy = Y_W'(GLYPH_Y0) + Y_W'(r_gr);
    // (H-1-r)*W + (W-1-c) rewritten as (H*W-1) - (r*W + c): MSB is top-left.
    assign w_bit_idx = c_bit_w'(c_gbits - 1)
                     - (c_bit_w'(r_gr) * c_bit_w'(GLYPH_W) + c_bit_w'(r_gc));
    assign w_gmap = w_glyph[r_gk];

    always_comb begin
        w_state_nxt     = r_state;
        w_slot_nxt      = r_slot;
        w_cx_nxt        = r_cx;
        w_cy_nxt        = r_cy;
        w_gr_nxt        = r_gr;
        w_gc_nxt        = r_gc;
        w_gk_nxt        = r_gk;
        w_clr_latch_nxt = r_clr_latch;
        w_ret_nxt       = r_ret;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_col_nxt       = r_col;
        w_plot_nxt      = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_plot_nxt = 1'b1;
                if (r_slot == c_slot_w'(NUM_PLAYERS)) begin
                    // Timer pixel is always plotted; round-end decision here.
                    w_x_nxt    = timer_x;
                    w_y_nxt    = Y_W'(TIMER_Y);
                    w_col_nxt  = 3'b111;
                    w_slot_nxt = '0;
                    if (!running) begin
                        w_state_nxt     = ST_CLEAR;
                        w_ret_nxt       = 1'b0;
                        w_clr_latch_nxt = 1'b0;
                        w_cx_nxt        = '0;
                        w_cy_nxt        = '0;
                    end else if (r_clr_latch || clear_req) begin
                        w_state_nxt     = ST_CLEAR;
                        w_ret_nxt       = 1'b1;
                        w_clr_latch_nxt = 1'b0;
                        w_cx_nxt        = '0;
                        w_cy_nxt        = '0;
                    end
                end else begin
                    w_x_nxt    = w_px[w_pk];
                    w_y_nxt    = w_py[w_pk];
                    w_col_nxt  = w_pcol[w_pk];
                    w_slot_nxt = r_slot + c_slot_w'(1);
                    if (clear_req) begin
                        w_clr_latch_nxt = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                w_plot_nxt = 1'b1;
                w_x_nxt    = r_cx;
                w_y_nxt    = r_cy;
                w_col_nxt  = 3'b000;
                if (r_cy == Y_W'(Y_MAX)) begin
                    w_cy_nxt = '0;
                    if (r_cx == X_W'(X_MAX)) begin
                        w_cx_nxt = '0;
                        if (r_ret) begin
                            w_state_nxt = ST_RUN;
                            w_slot_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_GLYPH;
                            w_gr_nxt    = '0;
                            w_gc_nxt    = '0;
                            w_gk_nxt    = '0;
                        end
                    end else begin
                        w_cx_nxt = r_cx + X_W'(1);
                    end
                end else begin
                    w_cy_nxt = r_cy + Y_W'(1);
                end
            end

            ST_GLYPH: begin
                w_plot_nxt = 1'b1;
                w_x_nxt    = w_gx;
                w_y_nxt    = w_gy;
                w_col_nxt  = w_gmap[w_bit_idx] ? w_rcol[r_gk] : 3'b000;
                // Glyph index is innermost so each row is drawn across all
                // glyphs before moving down.
                if (r_gk == c_k_w'(NUM_PLAYERS - 1)) begin
                    w_gk_nxt = '0;
                    if (r_gc == c_col_w'(GLYPH_W - 1)) begin
                        w_gc_nxt = '0;
                        if (r_gr == c_row_w'(GLYPH_H - 1)) begin
                            w_gr_nxt    = '0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_gr_nxt = r_gr + c_row_w'(1);
                        end
                    end else begin
                        w_gc_nxt = r_gc + c_col_w'(1);
                    end
                end else begin
                    w_gk_nxt = r_gk + c_k_w'(1);
                end
            end

            ST_DONE: begin
                if (restart) begin
                    w_state_nxt = ST_CLEAR;
                    w_ret_nxt   = 1'b1;
                    w_cx_nxt    = '0;
                    w_cy_nxt    = '0;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_RUN;
            r_slot      <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_gr        <= '0;
            r_gc        <= '0;
            r_gk        <= '0;
            r_clr_latch <= 1'b0;
            r_ret       <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_col       <= '0;
            r_plot      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slot      <= w_slot_nxt;
            r_cx        <= w_cx_nxt;
            r_cy        <= w_cy_nxt;
            r_gr        <= w_gr_nxt;
            r_gc        <= w_gc_nxt;
            r_gk        <= w_gk_nxt;
            r_clr_latch <= w_clr_latch_nxt;
            r_ret       <= w_ret_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_col       <= w_col_nxt;
            r_plot      <= w_plot_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_col;
    assign plot   = r_plot;
    assign phase  = r_state;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_turf_plot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turf_plot_sequencer
//  Description : Directed self-checking bench for turf_plot_sequencer. A
//                default 4-player instance exercises RUN, clear request,
//                end-of-game clear, glyph rendering, DONE, restart and async
//                reset; a 2-player instance checks the reduced round and
//                glyph layout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turf_plot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 4-player instance ----------------
    logic         resetn, running, clear_req, restart;
    logic [59:0]  player_pos;
    logic [11:0]  player_colour, rank_colours;
    logic [7:0]   timer_x;
    logic [139:0] glyph_bits;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot, done;
    logic [1:0]   phase;

    turf_plot_sequencer dut (
        .CLOCK_50(clk), .resetn(resetn), .running(running),
        .clear_req(clear_req), .restart(restart),
        .player_pos(player_pos), .player_colour(player_colour),
        .timer_x(timer_x), .rank_colours(rank_colours), .glyph_bits(glyph_bits),
        .x(x), .y(y), .colour(colour), .plot(plot), .phase(phase), .done(done)
    );

    // ---------------- 2-player instance ----------------
    logic         resetn2, running2, clear_req2, restart2;
    logic [29:0]  player_pos2;
    logic [5:0]   player_colour2, rank_colours2;
    logic [7:0]   timer_x2;
    logic [69:0]  glyph_bits2;
    logic [7:0]   x2;
    logic [6:0]   y2;
    logic [2:0]   colour2;
    logic         plot2, done2;
    logic [1:0]   phase2;

    turf_plot_sequencer #(.NUM_PLAYERS(2), .GLYPH_PITCH(40)) dut2 (
        .CLOCK_50(clk), .resetn(resetn2), .running(running2),
        .clear_req(clear_req2), .restart(restart2),
        .player_pos(player_pos2), .player_colour(player_colour2),
        .timer_x(timer_x2), .rank_colours(rank_colours2), .glyph_bits(glyph_bits2),
        .x(x2), .y(y2), .colour(colour2), .plot(plot2), .phase(phase2), .done(done2)
    );

    logic [31:0] obs1, obs2;
    assign obs1 = {13'd0, x, y, colour, plot};
    assign obs2 = {13'd0, x2, y2, colour2, plot2};

    // Stimulus tables (hand-entered)
    int px[4]   = '{10, 20, 30, 40};
    int py[4]   = '{5, 6, 7, 8};
    int pc[4]   = '{2, 3, 4, 5};
    int px2[2]  = '{50, 60};
    int py2[2]  = '{9, 10};
    int pc2[2]  = '{1, 6};
    logic [34:0] glyph_tab [4];
    logic [2:0]  rank_tab  [4];
    logic [2:0]  rank2_tab [2];

    function automatic logic [31:0] pix(input int ex, input int ey, input int ec, input int ep);
        return {13'd0, ex[7:0], ey[6:0], ec[2:0], ep[0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One RUN step of the 4-player instance: k<4 player, k==4 timer pixel
    task automatic exp_run(input int k);
        tick;
        if (k < 4) chk("run_pix", obs1, pix(px[k], py[k], pc[k], 1));
        else       chk("run_timer", obs1, pix(3, 119, 7, 1));
    endtask

    task automatic exp_run2(input int k);
        tick;
        if (k < 2) chk("run2_pix", obs2, pix(px2[k], py2[k], pc2[k], 1));
        else       chk("run2_timer", obs2, pix(7, 119, 7, 1));
    endtask

    // Black sweep: x outer, y inner; optionally pulse clear_req at one step
    task automatic check_clear(input int stop_at, input int pulse_at);
        for (int i = 0; i < stop_at; i++) begin
            tick;
            chk("clear_pix", obs1, pix(i / 120, i % 120, 0, 1));
            clear_req = (i == pulse_at);
        end
        clear_req = 1'b0;
    endtask

    task automatic glyph_check(input int sel, input int n, input int pitch);
        logic [34:0] g;
        logic [2:0]  rc;
        int          idx, ec;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 5; c++) begin
                for (int k = 0; k < n; k++) begin
                    tick;
                    g   = glyph_tab[k];
                    rc  = (sel == 1) ? rank_tab[k] : rank2_tab[k];
                    idx = (6 - r) * 5 + (4 - c);
                    ec  = g[idx] ? int'(rc) : 0;
                    if (sel == 1) begin
                        chk("glyph_pix", obs1, pix(33 + k*pitch + c, 42 + r, ec, 1));
                        if (r == 0 && c == 0 && k == 0) chk("glyph_first", obs1, pix(33, 42, 1, 1));
                        if (r == 0 && c == 3 && k == 0) chk("glyph_c3_off", obs1, pix(36, 42, 0, 1));
                    end else begin
                        chk("glyph2_pix", obs2, pix(33 + k*pitch + c, 42 + r, ec, 1));
                        if (r == 0 && c == 0 && k == 1) chk("glyph2_x_lo", {24'd0, x2}, 32'd73);
                        if (r == 6 && c == 4 && k == 1) chk("glyph2_x_hi", {24'd0, x2}, 32'd77);
                    end
                end
            end
        end
    endtask

    initial begin
        glyph_tab[0] = 35'b11100_00100_00100_00100_00100_00100_11111;
        glyph_tab[1] = 35'b01110_10001_00001_00010_00100_01000_11111;
        glyph_tab[2] = 35'b11111_00010_00100_00010_00001_10001_01110;
        glyph_tab[3] = 35'b00010_00110_01010_10010_11111_00010_00010;
        rank_tab[0] = 3'b001; rank_tab[1] = 3'b010; rank_tab[2] = 3'b011; rank_tab[3] = 3'b100;
        rank2_tab[0] = 3'b101; rank2_tab[1] = 3'b110;

        resetn        = 1'b0;
        running       = 1'b1;
        clear_req     = 1'b0;
        restart       = 1'b0;
        player_pos    = {8'd40, 7'd8, 8'd30, 7'd7, 8'd20, 7'd6, 8'd10, 7'd5};
        player_colour = {3'd5, 3'd4, 3'd3, 3'd2};
        timer_x       = 8'd3;
        rank_colours  = {rank_tab[3], rank_tab[2], rank_tab[1], rank_tab[0]};
        glyph_bits    = {glyph_tab[3], glyph_tab[2], glyph_tab[1], glyph_tab[0]};

        resetn2        = 1'b0;
        running2       = 1'b1;
        clear_req2     = 1'b0;
        restart2       = 1'b0;
        player_pos2    = {8'd60, 7'd10, 8'd50, 7'd9};
        player_colour2 = {3'd6, 3'd1};
        timer_x2       = 8'd7;
        rank_colours2  = {rank2_tab[1], rank2_tab[0]};
        glyph_bits2    = {glyph_tab[1], glyph_tab[0]};

        repeat (3) tick;
        chk("reset_pix", obs1, pix(0, 0, 0, 0));
        chk("reset_phase_done", {29'd0, phase, done}, 32'd0);
        resetn = 1'b1;

        // Two full rounds, period 5
        for (int i = 0; i < 10; i++) exp_run(i % 5);

        // Clear request at slot 1: round completes, clear, back to RUN
        exp_run(0);
        clear_req = 1'b1;
        exp_run(1);
        clear_req = 1'b0;
        exp_run(2);
        exp_run(3);
        exp_run(4);
        chk("clrreq_phase", {30'd0, phase}, 32'd1);
        check_clear(19200, 1000);           // request mid-clear is ignored
        chk("clrreq_return_phase", {29'd0, phase, done}, {29'd0, 2'd0, 1'b0});
        for (int i = 0; i < 7; i++) exp_run(i % 5);

        // Drop running mid-round: timer pixel still plotted, then clear/glyph
        running = 1'b0;
        exp_run(2);
        exp_run(3);
        exp_run(4);
        chk("end_clear_phase", {29'd0, phase, done}, {29'd0, 2'd1, 1'b0});
        check_clear(19200, -1);
        chk("glyph_phase", {30'd0, phase}, 32'd2);
        glyph_check(1, 4, 30);
        tick;
        chk("done_hold_pix", obs1, pix(127, 48, 0, 0));
        chk("done_state", {29'd0, phase, done}, {29'd0, 2'd3, 1'b1});

        // running is ignored while DONE
        running = 1'b1;
        repeat (3) tick;
        chk("done_ignores_running", {28'd0, phase, done, plot}, {28'd0, 2'd3, 1'b1, 1'b0});

        // Restart: DONE -> CLEAR with return, then RUN
        restart = 1'b1;
        tick;
        restart = 1'b0;
        chk("restart_state", {28'd0, phase, done, plot}, {28'd0, 2'd1, 1'b0, 1'b0});
        check_clear(19200, -1);
        chk("restart_return_phase", {29'd0, phase, done}, 32'd0);
        exp_run(0);

        // Async reset in the middle of a clear sweep
        clear_req = 1'b1;
        exp_run(1);
        clear_req = 1'b0;
        exp_run(2);
        exp_run(3);
        exp_run(4);
        check_clear(500, -1);
        resetn = 1'b0;
        #1;
        chk("async_reset_pix", obs1, pix(0, 0, 0, 0));
        chk("async_reset_phase", {29'd0, phase, done}, 32'd0);
        tick;
        tick;
        resetn = 1'b1;
        exp_run(0);
        exp_run(1);

        // 2-player instance: period 3, 70-cycle glyph phase
        tick;
        resetn2 = 1'b1;
        exp_run2(0);
        exp_run2(1);
        exp_run2(2);
        exp_run2(0);
        running2 = 1'b0;
        exp_run2(1);
        exp_run2(2);
        chk("dut2_clear_phase", {30'd0, phase2}, 32'd1);
        repeat (19200) tick;
        chk("dut2_glyph_phase", {30'd0, phase2}, 32'd2);
        glyph_check(2, 2, 40);
        tick;
        chk("dut2_done", {28'd0, phase2, done2, plot2}, {28'd0, 2'd3, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
